// File: rtl/seg_scan_controller_pkg.sv
// Shared definitions for the eight-digit seven-segment scan controller.
//   scan_state_e : slot phase (SCAN_BLANK = all anodes off, SCAN_DRIVE = digit lit)
//   ANODES_OFF   : active-low anode pattern with every digit dark
//   HEX_SEGMENTS : hex nibble to segment pattern, bit order {g,f,e,d,c,b,a},
//                  active-high (a segment bit of 1 means the segment is lit)
package seg_scan_controller_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Entry 0 is the rightmost element, so the list reads F down to 0.
  localparam logic [15:0][6:0] HEX_SEGMENTS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_controller_seven_segment.sv
// Hex nibble to seven-segment decoder (purely combinational).
//   nibble   : 4-bit hex value 0-F
//   segments : {g,f,e,d,c,b,a}, active-high
module seg_scan_controller_seven_segment
  import seg_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_SEGMENTS[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for an eight-digit seven-segment display.
// Each digit owns a slot of TICKS_PER_DIGIT cycles: the first BLANK_TICKS
// cycles keep every anode off (anti-ghosting), the rest drive that digit.
// Input values are staged on load and only become visible at a frame wrap,
// so a frame never mixes old and new digits.
//   CLK100MHZ  : system clock
//   reset      : synchronous, active-high
//   data       : eight hex nibbles, nibble i goes to digit i
//   digit_en   : per-digit enable, 0 keeps the digit dark
//   dp         : per-digit decimal point, active-high
//   load       : one-cycle strobe capturing data/digit_en/dp into staging
//   pending    : a staged value is waiting for the next frame wrap
//   frame_done : high during the last cycle of digit NUM_DIGITS-1's slot
//   CA..CG, DP : segment cathodes, active-low, registered
//   AN         : anodes, active-low, registered
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int NUM_DIGITS      = 8
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int TICK_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK_END = TICK_W'(BLANK_TICKS);
  localparam logic [2:0]        IDX_LAST       = 3'(NUM_DIGITS - 1);

  scan_state_e       state, state_next;
  logic [TICK_W-1:0] tick, tick_next;
  logic [2:0]        idx, idx_next;
  logic              slot_end, frame_wrap;

  logic [31:0] staged_data, active_data;
  logic [7:0]  staged_en, active_en;
  logic [7:0]  staged_dp, active_dp;

  logic [3:0]  nibble;
  logic [6:0]  seg_on;
  logic [7:0]  an_next;
  logic [6:0]  seg_next, seg_q;
  logic        dp_next;

  assign slot_end   = (tick == TICK_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign frame_done = frame_wrap;

  assign nibble = active_data[{idx, 2'b00} +: 4];

  seg_scan_controller_seven_segment u_decoder (
    .nibble   (nibble),
    .segments (seg_on)
  );

  // The state always follows the tick the counter is about to hold, so the
  // BLANK/DRIVE phase never lags the slot position.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    tick_next = tick + 1'b1;
    idx_next  = idx;
    an_next   = ANODES_OFF;
    seg_next  = 7'h7F;
    dp_next   = 1'b1;

    if (slot_end) begin
      tick_next = '0;
      idx_next  = frame_wrap ? 3'd0 : idx + 1'b1;
    end
    state_next = (tick_next < TICK_BLANK_END) ? SCAN_BLANK : SCAN_DRIVE;

    if (state == SCAN_DRIVE) begin
      if (active_en[idx]) an_next[idx] = 1'b0;
      seg_next = ~seg_on;
      dp_next  = ~active_dp[idx];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge values, independent of statement order.
    if (reset) begin
      state <= SCAN_BLANK;
      tick  <= '0;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      idx   <= idx_next;
    end
  end

  // A load coinciding with a wrap commits the old staged value and captures
  // the new one, which leaves pending set for the following wrap.
  always_ff @(posedge CLK100MHZ) begin
    // NOTE: the data registers are reset too, because a dark display after reset relies on active_en being cleared and staged data being discarded.
    if (reset) begin
      staged_data <= '0;
      staged_en   <= '0;
      staged_dp   <= '0;
      active_data <= '0;
      active_en   <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
    end else begin
      if (load) begin
        staged_data <= data;
        staged_en   <= digit_en;
        staged_dp   <= dp;
      end
      if (frame_wrap && pending) begin
        active_data <= staged_data;
        active_en   <= staged_en;
        active_dp   <= staged_dp;
      end
      pending <= load | (pending & ~frame_wrap);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      AN    <= ANODES_OFF;
      seg_q <= 7'h7F;
      DP    <= 1'b1;
    end else begin
      AN    <= an_next;
      seg_q <= seg_next;
      DP    <= dp_next;
    end
  end

  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed testbench for seg_scan_controller with a short slot
// (4 ticks, 1 blank tick, 8 digits => 32-cycle frame).
module tb_seg_scan_controller;

  localparam int TPD = 4;
  localparam int BLK = 1;
  localparam int ND  = 8;

  // Active-low {CG,CF,CE,CD,CC,CB,CA} for hex 0..F.
  localparam logic [6:0] SEG_LOW [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic        load;
  logic        pending, frame_done;
  logic        ca, cb, cc, cd, ce, cf, cg, dp_pin;
  logic [7:0]  an;
  logic [6:0]  seg_pins;

  int tests_run    = 0;
  int tests_failed = 0;

  assign seg_pins = {cg, cf, ce, cd, cc, cb, ca};

  always #5 clk = ~clk;

  seg_scan_controller #(
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BLK),
    .NUM_DIGITS      (ND)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .data       (data),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .CA         (ca),
    .CB         (cb),
    .CC         (cc),
    .CD         (cd),
    .CE         (ce),
    .CF         (cf),
    .CG         (cg),
    .DP         (dp_pin),
    .AN         (an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until frame_done is seen; n = cycles advanced.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic check_dark_reset(input string tag);
    check({tag, " AN"},         an,         8'hFF);
    check({tag, " seg"},        seg_pins,   7'h7F);
    check({tag, " DP"},         dp_pin,     1'b0 ^ 1'b1);
    check({tag, " pending"},    pending,    1'b0);
    check({tag, " frame_done"}, frame_done, 1'b0);
  endtask

  // Entered at cycle W + first_c - 1, where W is a frame_done cycle.
  // Pins at W+2+4k are the blank of slot k, W+3+4k..W+5+4k its drive cycles.
  task automatic check_frame(input int first_c, input logic [31:0] d,
                             input logic [7:0] en, input logic [7:0] dpv,
                             input logic exp_pend);
    for (int c = first_c; c <= 33; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c == 2) check("pending after wrap", pending, exp_pend);
      if (c >= 2) begin
        int p, k, ph;
        logic [7:0] an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        p  = c - 2;
        k  = p / 4;
        ph = p % 4;
        an_exp  = 8'hFF;
        seg_exp = 7'h7F;
        dp_exp  = 1'b1;
        if (ph != 0) begin
          if (en[k]) an_exp[k] = 1'b0;
          seg_exp = SEG_LOW[d[4*k +: 4]];
          dp_exp  = ~dpv[k];
        end
        check($sformatf("AN c%0d", c),  an,       an_exp);
        check($sformatf("seg c%0d", c), seg_pins, seg_exp);
        check($sformatf("DP c%0d", c),  dp_pin,   dp_exp);
        check($sformatf("frame_done c%0d", c), frame_done, (c == 32) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dpv);
    data     = d;
    digit_en = en;
    dp       = dpv;
    load     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b1;
    data     = '0;
    digit_en = '0;
    dp       = '0;
    load     = 1'b0;

    // Reset held three cycles, then dark frames with a 32-cycle period.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_dark_reset("reset");
    reset = 1'b0;
    wait_frame(n);
    check("first frame latency", n, 31);
    check_frame(1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Single load, committed at the next wrap.
    do_load(32'h7654_3210, 8'hFF, 8'h00);
    @(negedge clk);
    load = 1'b0;
    check("pending after load", pending, 1'b1);
    wait_frame(n);
    check("pending before wrap", pending, 1'b1);
    check_frame(1, 32'h7654_3210, 8'hFF, 8'h00, 1'b0);

    // Only digit 0 enabled, with its decimal point.
    do_load(32'hFEDC_BA98, 8'h01, 8'h01);
    @(negedge clk);
    load = 1'b0;
    wait_frame(n);
    check_frame(1, 32'hFEDC_BA98, 8'h01, 8'h01, 1'b0);

    // Back-to-back loads (last wins) plus a load in the frame_done cycle.
    do_load(32'h1111_1111, 8'hFF, 8'h00);
    @(negedge clk);
    do_load(32'h2222_2222, 8'hFF, 8'h0F);
    @(negedge clk);
    load = 1'b0;
    check("pending after two loads", pending, 1'b1);
    wait_frame(n);
    do_load(32'h89AB_CDEF, 8'h5A, 8'hC3);
    check_frame(1, 32'h2222_2222, 8'hFF, 8'h0F, 1'b1);
    check_frame(2, 32'h89AB_CDEF, 8'h5A, 8'hC3, 1'b0);

    // Reset in the middle of digit 3's drive with a load pending.
    do_load(32'hFFFF_FFFF, 8'hFF, 8'hFF);
    @(negedge clk);
    load = 1'b0;
    repeat (13) @(negedge clk);
    check("digit3 drive AN", an, 8'hF7);
    check("pending before reset", pending, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_dark_reset("mid reset");
    reset = 1'b0;
    wait_frame(n);
    check("frame latency after reset", n, 31);
    check_frame(1, 32'h0, 8'h00, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
